// File: rtl/ws2812b_serializer.sv
// ws2812b_serializer: turns 24-bit GRB pixel words into WS2812B NRZ pulses on one LED line.
// Latency: led rises in the first cycle after the accepting edge. A frame lasts 24*TBIT_CYC cycles,
//          plus TRESET_CYC cycles when the word is flagged latch.
// Backpressure: ready is high only in IDLE. Inputs are ignored while a frame or latch period is running.
//
// Ports:
//   clk      - project clock (64 MHz nominal; all timing is counted in cycles)
//   rst_n    - synchronous active-low reset; aborts any frame in progress
//   data_in  - pixel word {G, R, B}; bit 23 goes out first
//   valid    - data_in and latch are valid this cycle
//   latch    - hold the line low for the strip latch period after this word
//   ready    - registered; high when a word can be accepted
//   led      - registered serial output to the strip
module ws2812b_serializer #(
  parameter int T0H_CYC    = 26,
  parameter int T1H_CYC    = 51,
  parameter int TBIT_CYC   = 80,
  parameter int TRESET_CYC = 5120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        led
);

  // One counter serves both the bit period and the latch period, so it is
  // sized for whichever of the two is longer.
  localparam int MAX_CYC = (TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC;
  localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CYC_W-1:0] C_T0H_LAST    = CYC_W'(T0H_CYC - 1);
  localparam logic [CYC_W-1:0] C_T1H_LAST    = CYC_W'(T1H_CYC - 1);
  localparam logic [CYC_W-1:0] C_TBIT_LAST   = CYC_W'(TBIT_CYC - 1);
  localparam logic [CYC_W-1:0] C_TRESET_LAST = CYC_W'(TRESET_CYC - 1);
  localparam logic [CYC_W-1:0] C_CYC_ONE     = CYC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t           r_state;
  logic [23:0]      r_shift;
  logic [4:0]       r_bit_cnt;
  logic [CYC_W-1:0] r_cyc;
  logic             r_latch_q;
  logic             r_led;
  logic             r_ready;

  // Last high cycle of the current bit, chosen by the bit now at the MSB.
  logic [CYC_W-1:0] w_th_last;
  assign w_th_last = r_shift[23] ? C_T1H_LAST : C_T0H_LAST;

  assign ready = r_ready;
  assign led   = r_led;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= 24'd0;
      r_bit_cnt <= 5'd0;
      r_cyc     <= '0;
      r_latch_q <= 1'b0;
      r_led     <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The line rises on the accepting edge itself, so the first high
          // cycle is the cycle right after the handshake.
          if (valid && r_ready) begin
            r_shift   <= data_in;
            r_latch_q <= latch;
            r_bit_cnt <= 5'd23;
            r_cyc     <= '0;
            r_led     <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= S_HIGH;
          end
        end

        S_HIGH: begin
          // cyc keeps running into LOW so the whole bit is timed from one origin.
          r_cyc <= r_cyc + C_CYC_ONE;
          if (r_cyc == w_th_last) begin
            r_led   <= 1'b0;
            r_state <= S_LOW;
          end
        end

        S_LOW: begin
          r_cyc <= r_cyc + C_CYC_ONE;
          if (r_cyc == C_TBIT_LAST) begin
            r_cyc <= '0;
            if (r_bit_cnt != 5'd0) begin
              r_shift   <= {r_shift[22:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 5'd1;
              r_led     <= 1'b1;
              r_state   <= S_HIGH;
            end else if (r_latch_q) begin
              r_state <= S_LATCH;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end

        S_LATCH: begin
          r_cyc <= r_cyc + C_CYC_ONE;
          if (r_cyc == C_TRESET_LAST) begin
            r_cyc     <= '0;
            r_latch_q <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_led   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_serializer.sv
module tb_ws2812b_serializer;

  localparam int T0H    = 26;
  localparam int T1H    = 51;
  localparam int TBIT   = 80;
  localparam int TRESET = 5120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_in = 24'd0;
  logic        valid = 1'b0;
  logic        latch = 1'b0;
  logic        ready;
  logic        led;

  ws2812b_serializer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .valid   (valid),
    .latch   (latch),
    .ready   (ready),
    .led     (led)
  );

  always #8 clk = ~clk;

  // Edge index: at the negedge following posedge k, tcount == k.
  longint tcount = 0;
  always @(posedge clk) tcount <= tcount + 1;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, tcount);
    end
  endtask

  // Expected frame: the word, its latch flag and the edge index at which it is accepted.
  typedef struct {
    logic [23:0] w;
    bit          l;
    longint      acc;
  } exp_t;
  exp_t sb_q[$];

  // ---------------- monitor: decodes the led line and checks it against the queue
  int          m_bits = 0;
  bit          m_pend = 0;
  longint      m_last = 0;
  longint      m_ready_at = 0;
  longint      m_gap = 0;
  logic [23:0] m_word = 24'd0;
  bit          prev_led = 0;
  bit          prev_ready = 0;

  always @(negedge clk) begin
    exp_t e;
    longint width;
    if (!rst_n) begin
      m_bits     = 0;
      m_pend     = 0;
      prev_led   = led;
      prev_ready = ready;
    end else begin
      if (led && !prev_led) begin
        if (m_pend) begin
          chk("led_rise_in_tail", 1, 0);
        end else if (m_bits == 0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = sb_q[0];
            chk("first_rise_latency", tcount, e.acc);
            m_gap = tcount - m_last;
          end
        end else begin
          chk("bit_period", tcount - m_last, TBIT);
        end
        m_last = tcount;
      end
      if (!led && prev_led && !m_pend && sb_q.size() > 0) begin
        e     = sb_q[0];
        width = tcount - m_last;
        chk("high_width", width, e.w[5'(23 - m_bits)] ? T1H : T0H);
        m_word = {m_word[22:0], (width == T1H)};
        m_bits++;
        if (m_bits == 24) begin
          e = sb_q.pop_front();
          chk("word", m_word, e.w);
          m_ready_at = e.acc + 24 * TBIT + (e.l ? TRESET : 0);
          m_pend = 1;
          m_bits = 0;
        end
      end
      if (ready && !prev_ready) begin
        if (!m_pend) chk("ready_early", 1, 0);
        else chk("ready_return", tcount, m_ready_at);
        m_pend = 0;
      end
      prev_led   = led;
      prev_ready = ready;
    end
  end

  // ---------------- driver tasks
  task automatic send_word(input logic [23:0] w, input bit l, input bit hold);
    bit got;
    @(posedge clk); #1;
    data_in = w;
    latch   = l;
    valid   = 1'b1;
    got     = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 1, 0);
      valid = 1'b0;
      return;
    end
    sb_q.push_back('{w: w, l: l, acc: tcount + 1});
    @(posedge clk); #1;
    data_in = 24'($urandom);
    if (!hold) begin
      valid = 1'b0;
      latch = 1'($urandom);
    end
    @(negedge clk);
    chk("ready_drop", ready, 0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !m_pend && ready) done = 1;
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    valid = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("reset_led_next", led, 0);
    chk("reset_ready_next", ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus
  initial begin
    int bad;
    logic [23:0] w;
    bit l, h;

    // Reset and a long idle stretch.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_led", led, 0);
    chk("reset_ready", ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (led !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("idle_hold", bad, 0);

    // Mixed ones and zeros, no latch.
    send_word(24'hFF0000, 1'b0, 1'b0);
    wait_idle();

    // Latch period after the last bit.
    send_word(24'hAA55C3, 1'b1, 1'b0);
    wait_idle();

    // Back-to-back with valid held high between words.
    send_word(24'h000001, 1'b0, 1'b1);
    send_word(24'h800000, 1'b0, 1'b0);
    wait_idle();
    chk("b2b_rise_gap", m_gap, TBIT + 1);

    // A valid pulse while busy must be ignored.
    send_word(24'h3C5A96, 1'b0, 1'b0);
    repeat (98) @(posedge clk);
    #1;
    valid   = 1'b1;
    data_in = 24'h123456;
    latch   = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    latch = 1'b0;
    wait_idle();

    // Reset in the middle of a frame, then a clean word.
    send_word(24'hA5A5A5, 1'b0, 1'b0);
    repeat (10 * TBIT + 20) @(posedge clk);
    do_reset();
    send_word(24'h0F0F0F, 1'b0, 1'b0);
    wait_idle();

    // Randomised words, latch flags, gaps and back-to-back runs.
    for (int k = 0; k < 8; k++) begin
      w = 24'($urandom);
      l = ($urandom_range(0, 3) == 0);
      h = 1'($urandom_range(0, 1));
      send_word(w, l, h);
      if (!h) repeat ($urandom_range(0, 5)) @(posedge clk);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
